// File: rtl/sseg_capture.sv
// sseg_capture: recovers the four digits shown on a multiplexed
// 7-segment bus as raw patterns, hex nibbles and frame pulses.
module sseg_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 2**20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  sseg,
  input  logic [3:0]  an,
  output logic [27:0] ssegValues,
  output logic [15:0] hex,
  output logic [3:0]  hex_valid,
  output logic        frame_valid,
  output logic        err,
  output logic        stale
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(SETTLE);
  localparam logic [CW-1:0] CSMP = CW'(SETTLE - 1);
  localparam logic [IW-1:0] IMAX = IW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_WAIT,
    S_SAMPLE,
    S_HOLD
  } state_e;

  logic [10:0]   s1_q;
  logic [10:0]   s2_q;
  logic [10:0]   prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          chg;

  state_e        st_q;
  logic [IW-1:0] idle_q;
  logic [3:0]    seen_q;
  logic [27:0]   vals_q;
  logic [15:0]   hex_q;
  logic [3:0]    hv_q;
  logic          fv_q;
  logic          err_q;

  logic [3:0]    an_s;
  logic [6:0]    seg_s;
  logic [1:0]    idx;
  logic [3:0]    dbit;
  logic          one;
  logic          multi;
  logic [4:0]    dv;

  function automatic logic [4:0] dec(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = 5'h10;
      7'b1111001: r = 5'h11;
      7'b0100100: r = 5'h12;
      7'b0110000: r = 5'h13;
      7'b0011001: r = 5'h14;
      7'b0010010: r = 5'h15;
      7'b0000010: r = 5'h16;
      7'b1111000: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0010000: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b0000011: r = 5'h1B;
      7'b1000110: r = 5'h1C;
      7'b0100001: r = 5'h1D;
      7'b0000110: r = 5'h1E;
      7'b0001110: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  assign chg = (s2_q != prev_q);

  always_comb begin
    cnt_d = cnt_q;
    if (chg) begin
      cnt_d = '0;
    end else if (cnt_q != CMAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= '1;
      s2_q   <= '1;
      prev_q <= '1;
      cnt_q  <= '0;
    end else begin
      s1_q   <= {an, sseg};
      s2_q   <= s1_q;
      prev_q <= s2_q;
      cnt_q  <= cnt_d;
    end
  end

  // prev_q still holds the settled value even if the bus moves in SAMPLE
  assign an_s  = prev_q[10:7];
  assign seg_s = prev_q[6:0];
  assign dv    = dec(seg_s);
  assign dbit  = 4'b0001 << idx;

  always_comb begin
    idx   = 2'd0;
    one   = 1'b1;
    multi = 1'b0;
    unique case (an_s)
      4'b1110: idx = 2'd3;
      4'b1101: idx = 2'd2;
      4'b1011: idx = 2'd1;
      4'b0111: idx = 2'd0;
      4'b1111: one = 1'b0;
      default: begin
        one   = 1'b0;
        multi = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= S_WAIT;
      idle_q <= '0;
      seen_q <= '0;
      vals_q <= 28'h7FFFFFF;
      hex_q  <= '0;
      hv_q   <= '0;
      fv_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      fv_q  <= 1'b0;
      err_q <= 1'b0;
      // any single-digit capture counts as activity, decoded or not
      if (st_q == S_SAMPLE && one) begin
        idle_q <= '0;
      end else if (idle_q != IMAX) begin
        idle_q <= idle_q + 1'b1;
      end
      unique case (st_q)
        S_WAIT: begin
          if (cnt_d == CSMP) begin
            st_q <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          st_q <= chg ? S_WAIT : S_HOLD;
          if (multi) begin
            err_q <= 1'b1;
          end
          if (one) begin
            vals_q[7*idx +: 7] <= seg_s;
            hex_q[4*idx +: 4]  <= dv[3:0];
            hv_q[idx]          <= dv[4];
            if ((seen_q | dbit) == 4'hF) begin
              fv_q   <= 1'b1;
              seen_q <= '0;
            end else begin
              seen_q <= seen_q | dbit;
            end
          end
        end
        S_HOLD: begin
          if (chg) begin
            st_q <= S_WAIT;
          end
        end
        default: st_q <= S_WAIT;
      endcase
    end
  end

  assign ssegValues  = vals_q;
  assign hex         = hex_q;
  assign hex_valid   = hv_q;
  assign frame_valid = fv_q;
  assign err         = err_q;
  assign stale       = (idle_q == IMAX);

endmodule
